systolic_array_is_sequencer: RTL and testbench

// - Drives one input-stationary systolic array and collects its results; sits between the on-chip buffers and the array.
// - Loads the stationary input tile, then streams weight vectors; psum vectors come back in the same order.
// - Gates the array's global stall (process_en) so back-pressure on results never drops data.

---
 rtl/systolic_array_is_sequencer.sv | 157 +++++++++++++++
 tb/tb_systolic_array_is_sequencer.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_array_is_sequencer.sv
// Sequencer for one input-stationary systolic array: loads the stationary input tile, streams
// weight vectors, and collects psum vectors. The array is stalled whenever a result could be lost.
module systolic_array_is_sequencer #(
  parameter int unsigned INPUT_WIDTH  = 16,
  parameter int unsigned WEIGHT_WIDTH = 16,
  parameter int unsigned PSUM_WIDTH   = 32,
  parameter int unsigned ARRAY_HEIGHT = 4,
  parameter int unsigned ARRAY_WIDTH  = 4,
  parameter int unsigned PIPE_LATENCY = ARRAY_WIDTH + ARRAY_HEIGHT,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic [CNT_WIDTH-1:0]                 num_vec,
  output logic                                 busy,
  output logic                                 done,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [ARRAY_HEIGHT*INPUT_WIDTH-1:0]  in_data,
  input  logic                                 w_valid,
  output logic                                 w_ready,
  input  logic [ARRAY_WIDTH*WEIGHT_WIDTH-1:0]  w_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [ARRAY_HEIGHT*PSUM_WIDTH-1:0]   out_data,
  output logic                                 sa_input_en,
  output logic                                 sa_process_en,
  output logic [ARRAY_HEIGHT*INPUT_WIDTH-1:0]  sa_input_in,
  output logic [ARRAY_WIDTH*WEIGHT_WIDTH-1:0]  sa_weight_in,
  input  logic [ARRAY_HEIGHT*PSUM_WIDTH-1:0]   sa_psum_out
);

  typedef enum logic [2:0] {StIdle, StLoad, StStream, StDrain, StFin} state_e;

  localparam logic [CNT_WIDTH-1:0] LoadBeats  = CNT_WIDTH'(ARRAY_WIDTH);
  localparam logic [CNT_WIDTH-1:0] DrainBeats = CNT_WIDTH'(PIPE_LATENCY);
  localparam logic [CNT_WIDTH-1:0] CntOne     = CNT_WIDTH'(1);

  state_e                                state_q, state_d;
  logic [CNT_WIDTH-1:0]                  num_vec_q, num_vec_d;
  logic [CNT_WIDTH-1:0]                  cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]                  cnt_inc;
  logic [PIPE_LATENCY-1:0]               tag_q, tag_d;
  logic                                  out_valid_q, out_valid_d;
  logic [ARRAY_HEIGHT*PSUM_WIDTH-1:0]    out_data_q, out_data_d;
  logic                                  slot_free;
  logic                                  adv;
  logic                                  capture;

  assign cnt_inc   = cnt_q + CntOne;
  // The array may only advance if any psum it produces this cycle has somewhere to go.
  assign slot_free = !out_valid_q || out_ready;

  always_comb begin
    state_d      = state_q;
    num_vec_d    = num_vec_q;
    cnt_d        = cnt_q;
    done         = 1'b0;
    in_ready     = 1'b0;
    w_ready      = 1'b0;
    sa_input_en  = 1'b0;
    sa_weight_in = '0;
    adv          = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          num_vec_d = num_vec;
          cnt_d     = '0;
          state_d   = StLoad;
        end
      end
      StLoad: begin
        in_ready    = 1'b1;
        sa_input_en = in_valid;
        if (in_valid) begin
          cnt_d = cnt_inc;
          if (cnt_inc == LoadBeats) begin
            cnt_d   = '0;
            state_d = (num_vec_q == '0) ? StDrain : StStream;
          end
        end
      end
      StStream: begin
        sa_weight_in = w_data;
        adv          = w_valid && slot_free;
        w_ready      = adv;
        if (adv) begin
          cnt_d = cnt_inc;
          if (cnt_inc == num_vec_q) begin
            cnt_d   = '0;
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        adv = slot_free;
        if (adv) begin
          cnt_d = cnt_inc;
          if (cnt_inc == DrainBeats) begin
            cnt_d   = '0;
            state_d = StFin;
          end
        end
      end
      StFin: begin
        if (!out_valid_q) begin
          done    = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Tag 1 marks a real weight vector; its psum is on sa_psum_out when the tag exits.
  always_comb begin
    capture     = adv && tag_q[PIPE_LATENCY-1];
    tag_d       = tag_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (adv) begin
      tag_d = {tag_q[PIPE_LATENCY-2:0], state_q == StStream};
    end
    if (capture) begin
      out_valid_d = 1'b1;
      out_data_d  = sa_psum_out;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      num_vec_q   <= '0;
      cnt_q       <= '0;
      tag_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      num_vec_q   <= num_vec_d;
      cnt_q       <= cnt_d;
      tag_q       <= tag_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign busy          = (state_q != StIdle);
  assign sa_process_en = adv;
  assign sa_input_in   = in_data;
  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;

endmodule

// File: tb/tb_systolic_array_is_sequencer.sv
// Bench for systolic_array_is_sequencer: a behavioural input-stationary array model feeds psums back;
// a scoreboard queue of hand-computed psum vectors is checked by a separate output monitor.
module tb_systolic_array_is_sequencer;

  localparam int IW = 16;
  localparam int WW = 16;
  localparam int PW = 32;
  localparam int H  = 4;
  localparam int W  = 4;
  localparam int L  = W + H;
  localparam int CW = 16;

  logic              clk = 1'b0;
  logic              clk_run = 1'b1;
  logic              rst_n;
  logic              start;
  logic [CW-1:0]     num_vec;
  logic              busy, done;
  logic              in_valid, in_ready;
  logic [H*IW-1:0]   in_data;
  logic              w_valid, w_ready;
  logic [W*WW-1:0]   w_data;
  logic              out_valid, out_ready;
  logic [H*PW-1:0]   out_data;
  logic              sa_input_en, sa_process_en;
  logic [H*IW-1:0]   sa_input_in;
  logic [W*WW-1:0]   sa_weight_in;
  logic [H*PW-1:0]   sa_psum_out;

  systolic_array_is_sequencer #(
    .INPUT_WIDTH (IW),
    .WEIGHT_WIDTH(WW),
    .PSUM_WIDTH  (PW),
    .ARRAY_HEIGHT(H),
    .ARRAY_WIDTH (W),
    .PIPE_LATENCY(L),
    .CNT_WIDTH   (CW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .num_vec      (num_vec),
    .busy         (busy),
    .done         (done),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .w_valid      (w_valid),
    .w_ready      (w_ready),
    .w_data       (w_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .sa_input_en  (sa_input_en),
    .sa_process_en(sa_process_en),
    .sa_input_in  (sa_input_in),
    .sa_weight_in (sa_weight_in),
    .sa_psum_out  (sa_psum_out)
  );

  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;
  int out_beats = 0;
  int done_cnt = 0;
  logic chk_w = 1'b0;
  logic [H*PW-1:0] sb[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Array model: beat c of the input tile is stationary column c; a psum vector leaves
  // exactly L process_en cycles after its weight vector entered.
  logic signed [IW-1:0] stat [H][W];
  logic [H*PW-1:0]      apipe [L];
  int unsigned          load_col;

  function automatic logic [H*PW-1:0] array_mac(input logic [W*WW-1:0] wv);
    logic [H*PW-1:0] res;
    logic signed [PW-1:0] acc, a, b;
    for (int r = 0; r < H; r++) begin
      acc = '0;
      for (int c = 0; c < W; c++) begin
        a = stat[r][c];
        b = signed'(wv[c*WW +: WW]);
        acc = acc + a * b;
      end
      res[r*PW +: PW] = acc;
    end
    return res;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_col <= 0;
      for (int i = 0; i < L; i++) apipe[i] <= '0;
    end else begin
      if (sa_input_en) begin
        for (int r = 0; r < H; r++) stat[r][load_col] <= sa_input_in[r*IW +: IW];
        load_col <= (load_col + 1) % W;
      end
      if (sa_process_en) begin
        apipe[0] <= array_mac(sa_weight_in);
        for (int i = 1; i < L; i++) apipe[i] <= apipe[i-1];
      end
    end
  end
  assign sa_psum_out = apipe[L-1];

  // Output monitor: pops the scoreboard on every accepted out beat.
  always @(negedge clk) begin
    logic [H*PW-1:0] e;
    if (rst_n) begin
      if (done) done_cnt++;
      if (chk_w && !w_valid) check("w_ready while starved", {127'b0, w_ready}, 128'd0);
      if (out_valid && out_ready) begin
        out_beats++;
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL out beat: got unexpected beat %h, expected none", out_data);
        end else begin
          e = sb.pop_front();
          check("out beat", out_data, e);
        end
      end
    end
  end

  function automatic logic [H*IW-1:0] pk_in(input int a0, input int a1, input int a2, input int a3);
    return {16'(a3), 16'(a2), 16'(a1), 16'(a0)};
  endfunction

  function automatic logic [H*PW-1:0] pk_p(input int a0, input int a1, input int a2, input int a3);
    return {32'(a3), 32'(a2), 32'(a1), 32'(a0)};
  endfunction

  task automatic start_tile(input int n);
    start = 1'b1;
    num_vec = CW'(n);
    @(posedge clk); #1;
    start = 1'b0;
    num_vec = CW'(7);
    check("busy after start", {127'b0, busy}, 128'd1);
  endtask

  task automatic send_input(input logic [H*IW-1:0] d);
    int t = 0;
    in_valid = 1'b1;
    in_data = d;
    @(negedge clk);
    while (!in_ready && t < 100) begin @(negedge clk); t++; end
    check("in_ready", {127'b0, in_ready}, 128'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic load_ones();
    for (int c = 0; c < W; c++) send_input(pk_in(1, 1, 1, 1));
  endtask

  task automatic send_w(input logic [W*WW-1:0] d);
    int t = 0;
    w_valid = 1'b1;
    w_data = d;
    @(negedge clk);
    while (!w_ready && t < 300) begin @(negedge clk); t++; end
    check("w_ready", {127'b0, w_ready}, 128'd1);
    @(posedge clk); #1;
    w_valid = 1'b0;
  endtask

  task automatic std_weights(input bit gaps);
    sb.push_back(pk_p(10, 10, 10, 10));
    sb.push_back(pk_p(0, 0, 0, 0));
    sb.push_back(pk_p(-4, -4, -4, -4));
    send_w(pk_in(1, 2, 3, 4));
    if (gaps) begin @(posedge clk); #1; end
    send_w(pk_in(0, 0, 0, 0));
    if (gaps) begin @(posedge clk); #1; end
    send_w(pk_in(-1, -1, -1, -1));
  endtask

  task automatic wait_done(input string name);
    int t = 0;
    @(negedge clk);
    while (!done && t < 400) begin @(negedge clk); t++; end
    check({name, " done"}, {127'b0, done}, 128'd1);
    check({name, " all beats out"}, 128'(sb.size()), 128'd0);
    @(negedge clk);
    check({name, " done one cycle"}, {126'b0, done, busy}, 128'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int b0, cyc;
    rst_n = 1'b0; start = 1'b0; num_vec = '0;
    in_valid = 1'b0; in_data = '0; w_valid = 1'b0; w_data = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk); #1;
    check("reset ctrl", {121'b0, busy, done, out_valid, in_ready, w_ready, sa_input_en,
                         sa_process_en}, 128'd0);
    check("reset out_data", out_data, 128'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Back-to-back tile.
    b0 = out_beats;
    start_tile(3);
    load_ones();
    std_weights(1'b0);
    wait_done("A");
    check("A beat count", 128'(out_beats - b0), 128'd3);

    // Result back-pressure for 20 cycles after the first out_valid.
    b0 = out_beats;
    out_ready = 1'b0;
    start_tile(3);
    load_ones();
    fork
      std_weights(1'b0);
      begin
        int t = 0, pe = 0, chg = 0;
        logic [H*PW-1:0] held;
        @(negedge clk);
        while (!out_valid && t < 300) begin @(negedge clk); t++; end
        check("bp out_valid", {127'b0, out_valid}, 128'd1);
        held = out_data;
        check("bp first data", held, pk_p(10, 10, 10, 10));
        repeat (20) begin
          @(negedge clk);
          if (sa_process_en) pe++;
          if (out_data !== held || !out_valid) chg++;
        end
        check("bp process_en stalled", 128'(pe), 128'd0);
        check("bp out_data stable", 128'(chg), 128'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    wait_done("B");
    check("B beat count", 128'(out_beats - b0), 128'd3);

    // Weight starvation: w_valid toggles.
    b0 = out_beats;
    start_tile(3);
    load_ones();
    chk_w = 1'b1;
    std_weights(1'b1);
    wait_done("C");
    chk_w = 1'b0;
    check("C beat count", 128'(out_beats - b0), 128'd3);

    // Empty tile: drain then FIN.
    b0 = out_beats;
    start_tile(0);
    load_ones();
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!done && cyc < 50);
    check("D done latency", 128'(cyc), 128'(L + 1));
    @(negedge clk);
    check("D idle after done", {126'b0, done, busy}, 128'd0);
    check("D beat count", 128'(out_beats - b0), 128'd0);
    @(posedge clk); #1;

    // start while busy must not relatch num_vec.
    b0 = out_beats;
    start_tile(2);
    send_input(pk_in(1, 1, 1, 1));
    start = 1'b1; num_vec = CW'(5);
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c < W; c++) send_input(pk_in(1, 1, 1, 1));
    start = 1'b1; num_vec = CW'(5);
    @(posedge clk); #1;
    start = 1'b0;
    sb.push_back(pk_p(10, 10, 10, 10));
    sb.push_back(pk_p(0, 0, 0, 0));
    send_w(pk_in(1, 2, 3, 4));
    send_w(pk_in(0, 0, 0, 0));
    wait_done("E");
    check("E beat count", 128'(out_beats - b0), 128'd2);

    // Signed, non-uniform tile with psums wider than 16 bits.
    b0 = out_beats;
    start_tile(2);
    send_input(pk_in(1, 2, 3, 4));
    send_input(pk_in(-1, -1, -1, -1));
    send_input(pk_in(0, 0, 0, 0));
    send_input(pk_in(2, 2, 2, 2));
    sb.push_back(pk_p(-2, 1, 4, 7));
    sb.push_back(pk_p(32767, 65534, 98301, 131068));
    send_w(pk_in(3, 1, 5, -2));
    send_w(pk_in(32767, 0, 0, 0));
    wait_done("F");
    check("F beat count", 128'(out_beats - b0), 128'd2);

    // Asynchronous reset mid-tile with the clock stopped.
    out_ready = 1'b0;
    start_tile(3);
    load_ones();
    std_weights(1'b0);
    cyc = 0;
    @(negedge clk);
    while (!out_valid && cyc < 300) begin @(negedge clk); cyc++; end
    check("G out_valid before reset", {127'b0, out_valid}, 128'd1);
    w_valid = 1'b1;
    clk_run = 1'b0;
    #20;
    rst_n = 1'b0;
    #3;
    check("G async reset ctrl", {121'b0, busy, done, out_valid, in_ready, w_ready, sa_input_en,
                                 sa_process_en}, 128'd0);
    check("G async reset out_data", out_data, 128'd0);
    sb.delete();
    w_valid = 1'b0;
    out_ready = 1'b1;
    #10;
    rst_n = 1'b1;
    clk_run = 1'b1;
    @(posedge clk); #1;
    check("G no done after reset", {127'b0, done}, 128'd0);

    b0 = out_beats;
    start_tile(3);
    load_ones();
    std_weights(1'b0);
    wait_done("H");
    check("H beat count", 128'(out_beats - b0), 128'd3);
    check("done pulse total", 128'(done_cnt), 128'd7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
